// File: rtl/fsk_frame_ctrl.sv
// fsk_frame_ctrl: 2FSK frame sequencer (preamble, sync word, payload).
// Define FSK_CRC8_EN to append a CRC-8 byte after the payload.
module fsk_frame_ctrl #(
  parameter int          CLK_DIV   = 16,
  parameter int          PRE_BITS  = 16,
  parameter logic [15:0] SYNC_WORD = 16'h2DD4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       enable,
  output logic       bit_out,
  output logic       bit_stb,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [7:0] PRE_LAST = 8'(PRE_BITS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SYNC = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_END  = 3'd5;
`ifdef FSK_CRC8_EN
  localparam logic [2:0] S_CRC  = 3'd4;
  localparam logic [2:0] S_TAIL = S_CRC;
`else
  localparam logic [2:0] S_TAIL = S_END;
`endif

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_bcnt;
  logic [7:0]    w_bcnt_nxt;
  logic [7:0]    r_bytes;
  logic [7:0]    w_bytes_nxt;
  logic [7:0]    r_fetch;
  logic [7:0]    r_hold;
  logic          r_hold_full;
  logic [7:0]    r_sreg;
  logic [7:0]    w_sreg_nxt;
  logic          r_underrun;
  logic          w_consume;
  logic          w_urun_set;
  logic          w_bit_end;
  logic          w_in_bit;
  logic          w_cur_bit;
  logic          w_xfer;
  logic          w_start_ok;
  logic [3:0]    w_sidx;
  logic [7:0]    w_tail_sync;
  logic [7:0]    w_tail_pay;

  logic r_enable;
  logic r_bit_out;
  logic r_bit_stb;
  logic r_busy;
  logic r_done;

  assign w_bit_end  = (r_tcnt == T_LAST);
  assign w_start_ok = (r_state == S_IDLE) & start;
  assign w_sidx     = 4'd15 - r_bcnt[3:0];

  assign data_ready = ~r_hold_full
                    & ((r_state == S_SYNC) | (r_state == S_PAY))
                    & (r_fetch != 8'd0);
  assign w_xfer     = data_valid & data_ready;

`ifdef FSK_CRC8_EN
  logic [7:0] r_crc;
  logic [7:0] w_crc_nxt;

  // One CRC step per transmitted payload bit (poly 0x07).
  assign w_crc_nxt = {r_crc[6:0], 1'b0}
                   ^ ((r_crc[7] ^ r_sreg[7]) ? 8'h07 : 8'h00);
  assign w_tail_sync = r_crc;
  assign w_tail_pay  = w_crc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= 8'h00;
    end else if (w_start_ok) begin
      r_crc <= 8'h00;
    end else if ((r_state == S_PAY) && w_bit_end) begin
      r_crc <= w_crc_nxt;
    end
  end
`else
  assign w_tail_sync = 8'h00;
  assign w_tail_pay  = 8'h00;
`endif

  always_comb begin
    w_in_bit = (r_state == S_PRE)
             | (r_state == S_SYNC)
             | (r_state == S_PAY);
`ifdef FSK_CRC8_EN
    if (r_state == S_CRC) w_in_bit = 1'b1;
`endif
  end

  always_comb begin
    w_cur_bit = 1'b0;
    unique case (1'b1)
      (r_state == S_PRE):  w_cur_bit = ~r_bcnt[0];
      (r_state == S_SYNC): w_cur_bit = SYNC_WORD[w_sidx];
      default:             w_cur_bit = r_sreg[7];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_bytes_nxt = r_bytes;
    w_sreg_nxt  = r_sreg;
    w_consume   = 1'b0;
    w_urun_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_PRE;
          w_bcnt_nxt  = 8'd0;
          w_bytes_nxt = len;
        end
      end
      S_PRE: begin
        if (w_bit_end) begin
          w_bcnt_nxt = r_bcnt + 8'd1;
          if (r_bcnt == PRE_LAST) begin
            w_state_nxt = S_SYNC;
            w_bcnt_nxt  = 8'd0;
          end
        end
      end
      S_SYNC: begin
        if (w_bit_end) begin
          w_bcnt_nxt = r_bcnt + 8'd1;
          if (r_bcnt == 8'd15) begin
            w_bcnt_nxt = 8'd0;
            if (r_bytes == 8'd0) begin
              w_state_nxt = S_TAIL;
              w_sreg_nxt  = w_tail_sync;
            end else if (r_hold_full) begin
              w_state_nxt = S_PAY;
              w_sreg_nxt  = r_hold;
              w_consume   = 1'b1;
            end else begin
              w_state_nxt = S_END;
              w_urun_set  = 1'b1;
            end
          end
        end
      end
      S_PAY: begin
        if (w_bit_end) begin
          w_bcnt_nxt = r_bcnt + 8'd1;
          w_sreg_nxt = {r_sreg[6:0], 1'b0};
          if (r_bcnt == 8'd7) begin
            w_bcnt_nxt  = 8'd0;
            w_bytes_nxt = r_bytes - 8'd1;
            if (r_bytes == 8'd1) begin
              w_state_nxt = S_TAIL;
              w_sreg_nxt  = w_tail_pay;
            end else if (r_hold_full) begin
              w_sreg_nxt = r_hold;
              w_consume  = 1'b1;
            end else begin
              w_state_nxt = S_END;
              w_urun_set  = 1'b1;
            end
          end
        end
      end
`ifdef FSK_CRC8_EN
      S_CRC: begin
        if (w_bit_end) begin
          w_bcnt_nxt = r_bcnt + 8'd1;
          w_sreg_nxt = {r_sreg[6:0], 1'b0};
          if (r_bcnt == 8'd7) begin
            w_state_nxt = S_END;
            w_bcnt_nxt  = 8'd0;
          end
        end
      end
`endif
      S_END: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_bcnt      <= 8'd0;
      r_bytes     <= 8'd0;
      r_fetch     <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_sreg      <= 8'd0;
      r_underrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_bytes <= w_bytes_nxt;
      r_sreg  <= w_sreg_nxt;
      if ((w_state_nxt != r_state) || !w_in_bit || w_bit_end) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_start_ok) begin
        r_fetch <= len;
      end else if (w_xfer) begin
        r_fetch <= r_fetch - 8'd1;
      end
      if (w_start_ok) begin
        r_hold_full <= 1'b0;
      end else if (w_xfer) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end else if (w_consume) begin
        r_hold_full <= 1'b0;
      end
      if (w_start_ok) begin
        r_underrun <= 1'b0;
      end else if (w_urun_set) begin
        r_underrun <= 1'b1;
      end
    end
  end

  // Modulator-facing outputs are registered one cycle behind the sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable  <= 1'b0;
      r_bit_out <= 1'b0;
      r_bit_stb <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_enable  <= w_in_bit;
      r_bit_out <= w_in_bit & w_cur_bit;
      r_bit_stb <= w_in_bit & (r_tcnt == '0);
      r_busy    <= (r_state != S_IDLE);
      r_done    <= (r_state == S_END) & ~r_underrun;
    end
  end

  assign enable   = r_enable;
  assign bit_out  = r_bit_out;
  assign bit_stb  = r_bit_stb;
  assign busy     = r_busy;
  assign done     = r_done;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_fsk_frame_ctrl.sv
// tb_fsk_frame_ctrl: frame-level model of fsk_frame_ctrl checked every cycle,
// plus literal expectations for bit sequences, frame lengths and CRC.
module tb_fsk_frame_ctrl;

  localparam int CD = 4;
  localparam int PB = 4;
`ifdef FSK_CRC8_EN
  localparam int CRCB = 8;
`else
  localparam int CRCB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       enable;
  logic       bit_out;
  logic       bit_stb;
  logic       busy;
  logic       done;
  logic       underrun;

  fsk_frame_ctrl #(
    .CLK_DIV(CD),
    .PRE_BITS(PB),
    .SYNC_WORD(16'h2DD4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .len(len),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .enable(enable),
    .bit_out(bit_out),
    .bit_stb(bit_stb),
    .busy(busy),
    .done(done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int edges = 0;
  int t_start = 0;
  bit frame_on = 1'b0;
  bit chk_en = 1'b0;
  bit m_urun = 1'b0;
  bit m_bits[$];
  logic [7:0] src_q[$];
  int src_sent = 0;
  int src_limit = 0;
  bit obs[$];
  int done_k;
  int done_n;
  int last_en;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] obs_word(input int s, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) begin
      w = {w[30:0], (s + i < obs.size()) ? obs[s + i] : 1'b0};
    end
    return w;
  endfunction

  initial forever begin
    @(posedge clk);
    edges++;
  end

  // Byte source: offers the next queued byte while its quota allows.
  initial forever begin
    @(posedge clk);
    if (data_valid && data_ready) begin
      void'(src_q.pop_front());
      src_sent++;
    end
    #1;
    data_valid = (src_q.size() > 0) && (src_sent < src_limit);
    data_in = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // Per-cycle comparison against the frame model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      int k;
      int tt;
      logic [4:0] want;
      logic wu;
      bit do_u;
      bit idle;
      want = 5'b0;
      wu = 1'b0;
      do_u = 1'b1;
      idle = 1'b1;
      if (frame_on) begin
        k = edges - t_start;
        tt = m_bits.size() * CD;
        idle = (k == 0) || (k >= tt + 1);
        if (k >= 1 && k <= tt) begin
          want = {1'b1, 1'b1, ((k - 1) % CD) == 0,
                  m_bits[(k - 1) / CD], 1'b0};
        end else if (k == tt + 1) begin
          want = {1'b1, 1'b0, 1'b0, 1'b0, ~m_urun};
        end
        if (m_urun) begin
          if (k == tt) do_u = 1'b0;
          wu = (k > tt);
        end
      end
      check("outputs", {busy, enable, bit_stb, bit_out, done}, want);
      if (do_u) check("underrun", underrun, wu);
      if (idle) check("ready_idle", data_ready, 1'b0);
    end
  end

  task automatic run_frame(input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input int lim, input int s1, input int s2,
                           input int abort_k);
    bit bits[$];
    logic [7:0] pb[$];
    logic [15:0] sw;
    logic [7:0] crc;
    bit ur;
    bit fb;
    int nsend;
    int tt;
    sw = 16'h2DD4;
    pb.delete();
    if (n > 0) pb.push_back(b0);
    if (n > 1) pb.push_back(b1);
    if (n > 2) pb.push_back(b2);
    ur = (lim < n);
    nsend = ur ? lim : n;
    for (int i = 0; i < PB; i++) bits.push_back(i % 2 == 0);
    for (int i = 15; i >= 0; i--) bits.push_back(sw[i]);
    for (int j = 0; j < nsend; j++)
      for (int b = 7; b >= 0; b--) bits.push_back(pb[j][b]);
    crc = 8'h00;
    for (int j = 0; j < n; j++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = crc[7] ^ pb[j][b];
        crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    if (!ur && CRCB > 0)
      for (int b = 7; b >= 0; b--) bits.push_back(crc[b]);
    src_q = pb;
    src_sent = 0;
    src_limit = lim;
    len = 8'(n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    m_bits = bits;
    m_urun = ur;
    t_start = edges;
    frame_on = 1'b1;
    obs.delete();
    done_k = -1;
    done_n = 0;
    last_en = -1;
    tt = bits.size() * CD;
    for (int i = 0; i <= tt + 3; i++) begin
      int k;
      @(negedge clk);
      k = edges - t_start;
      start = (k == s1) || (k == s2);
      if (bit_stb) obs.push_back(bit_out);
      if (done) begin
        done_n++;
        done_k = k;
      end
      if (enable) last_en = k;
      if (k == abort_k) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_outs",
          {data_ready, enable, bit_out, bit_stb, busy, done, underrun},
          7'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    run_frame(0, 8'h00, 8'h00, 8'h00, 0, -1, -1, -1);
    check("len0_stb_count", obs.size(), 20 + CRCB);
    check("len0_done_cycle", done_k, (PB + 16 + CRCB) * CD + 1);
    check("len0_bits", obs_word(0, 20), 32'hA2DD4);
    check("len0_done_pulses", done_n, 1);
`ifndef FSK_CRC8_EN
    check("len0_done_81", done_k, 81);
`endif

    run_frame(2, 8'hA5, 8'h3C, 8'h00, 2, -1, -1, -1);
    check("len2_done_cycle", done_k, (PB + 32 + CRCB) * CD + 1);
    check("len2_payload", obs_word(20, 16), 32'hA53C);
    check("len2_done_pulses", done_n, 1);

    run_frame(2, 8'hA5, 8'h3C, 8'h00, 1, -1, -1, -1);
    check("urun_no_done", done_n, 0);
    check("urun_flag", underrun, 1'b1);
    check("urun_last_enable", last_en, 112);
    check("urun_stb_count", obs.size(), 28);

    run_frame(1, 8'h01, 8'h00, 8'h00, 1, -1, -1, -1);
    check("urun_cleared", underrun, 1'b0);
    check("len1_done_cycle", done_k, (PB + 24 + CRCB) * CD + 1);
    check("len1_payload", obs_word(20, 8), 32'h01);
`ifdef FSK_CRC8_EN
    check("crc_byte", obs_word(28, 8), 32'h07);
`endif

    run_frame(2, 8'hA5, 8'h3C, 8'h00, 2, 30, 100, -1);
    check("restart_done_cycle", done_k, (PB + 32 + CRCB) * CD + 1);
    check("restart_payload", obs_word(20, 16), 32'hA53C);
    check("restart_done_pulses", done_n, 1);

    run_frame(3, 8'hC3, 8'h5A, 8'h0F, 3, -1, -1, 100);
    @(posedge clk);
    #1;
    frame_on = 1'b0;
    rst = 1'b1;
    src_q.delete();
    src_limit = 0;
    #1;
    check("midrst_outs",
          {data_ready, enable, bit_out, bit_stb, busy, done, underrun},
          7'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_frame(3, 8'h11, 8'h22, 8'h33, 3, -1, -1, -1);
    check("len3_done_cycle", done_k, (PB + 40 + CRCB) * CD + 1);
    check("len3_payload", obs_word(20, 24), 32'h112233);
    check("len3_done_pulses", done_n, 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
